// File: rtl/or1200_checker_resp_pkg.sv
// Shared definitions for the OR1200 privilege-checker response block.
// Holds the FSM state encodings, viol_code bit positions and a saturating
// increment helper.
// Optional feature switch, disabled by default; define it to add first_tstamp:
// `define OR1200_CHECKER_RESP_TSTAMP_EN
package or1200_checker_resp_pkg;

   typedef enum logic [2:0] {
      ST_MONITOR = 3'd0,
      ST_FREEZE  = 3'd1,
      ST_EXCEPT  = 3'd2,
      ST_HOLDOFF = 3'd3,
      ST_LOCK    = 3'd4
   } chkState_e;

   localparam int VIOL_SR   = 0;
   localparam int VIOL_PIPE = 1;
   localparam int VIOL_MMU  = 2;
   localparam int VIOL_SUPV = 3;

   function automatic logic [7:0] satInc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/or1200_checker_resp_filter.sv
// Persistence filter: a raw violation must stay high for FILTER_CYCLES
// consecutive cycles before it is confirmed. Any low cycle restarts the count.
module or1200_checker_resp_filter #(
   parameter int FILTER_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   input  logic clear,
   output logic confirm
);

   localparam logic [3:0] LAST = 4'(FILTER_CYCLES - 1);

   logic [3:0] pcnt_q;
   logic [3:0] pcnt_d;

   // Count consecutive raw cycles, parking at the confirm value
   always_comb begin
      pcnt_d = pcnt_q;
      if (clear || !raw) begin
         pcnt_d = 4'd0;
      end else if (pcnt_q != LAST) begin
         pcnt_d = pcnt_q + 4'd1;
      end
   end

   // Counter register, cleared asynchronously by the active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcnt_q <= 4'd0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

   assign confirm = raw & (pcnt_q == LAST);

endmodule

// File: rtl/or1200_checker_resp.sv
// OR1200 privilege-checker response: filters checker violations, freezes the
// CPU, forces a one-cycle exception, and locks out after repeated violations.
// Optional: OR1200_CHECKER_RESP_TSTAMP_EN adds first_tstamp and a cycle counter.
module or1200_checker_resp
   import or1200_checker_resp_pkg::*;
#(
   parameter int FILTER_CYCLES  = 2,
   parameter int STALL_TIMEOUT  = 16,
   parameter int HOLDOFF_CYCLES = 8,
   parameter int MAX_VIOLATIONS = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        chk_en,
   input  logic        sr_ok,
   input  logic        pipeline_ok,
   input  logic        mmus_ok,
   input  logic [2:0]  secure_supv,
   input  logic        sr_sm,
   input  logic        cpu_stalled,
   input  logic        alarm_clr,
   output logic        freeze_req,
   output logic        except_req,
   output logic        alarm,
   output logic        locked,
   output logic [3:0]  viol_code,
   output logic [7:0]  viol_cnt,
`ifdef OR1200_CHECKER_RESP_TSTAMP_EN
   output logic [15:0] first_tstamp,
`endif
   output logic        supv_dec
);

   localparam logic [7:0] TOUT_LAST = 8'(STALL_TIMEOUT - 1);
   localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);
   localparam logic [7:0] MAX_VIOL  = 8'(MAX_VIOLATIONS);

   chkState_e  state_q, state_d;
   logic [7:0] tcnt_q, tcnt_d;
   logic [7:0] hcnt_q, hcnt_d;
   logic [7:0] violCnt_q, violCnt_d;
   logic [3:0] violCode_q, violCode_d;
   logic       alarm_q, alarm_d;
   logic       supvDec_q;
   logic       supvC;
   logic [3:0] cause;
   logic       raw;
   logic       confirm;
   logic [7:0] violCntInc;

   assign supvC = ~^secure_supv;

   assign cause[VIOL_SR]   = ~sr_ok;
   assign cause[VIOL_PIPE] = ~pipeline_ok;
   assign cause[VIOL_MMU]  = ~mmus_ok;
   assign cause[VIOL_SUPV] = supvC != sr_sm;

   assign raw        = chk_en & (|cause) & (state_q == ST_MONITOR);
   assign violCntInc = satInc8(violCnt_q);

   or1200_checker_resp_filter #(
      .FILTER_CYCLES(FILTER_CYCLES)
   ) u_filter (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw),
      .clear  (state_q != ST_MONITOR),
      .confirm(confirm)
   );

   // Next-state, counters and sticky status for the response sequence
   always_comb begin
      state_d    = state_q;
      tcnt_d     = 8'd0;
      hcnt_d     = 8'd0;
      violCnt_d  = violCnt_q;
      violCode_d = violCode_q;
      alarm_d    = alarm_q;
      case (state_q)
         ST_MONITOR: begin
            if (alarm_clr) begin
               alarm_d    = 1'b0;
               violCode_d = 4'd0;
            end
            if (confirm) begin
               state_d    = ST_FREEZE;
               alarm_d    = 1'b1;
               violCode_d = (alarm_clr ? 4'd0 : violCode_q) | cause;
            end
         end
         ST_FREEZE: begin
            tcnt_d = tcnt_q + 8'd1;
            if (cpu_stalled) begin
               state_d = ST_EXCEPT;
            end else if (tcnt_q == TOUT_LAST) begin
               state_d = ST_LOCK;
            end
         end
         ST_EXCEPT: begin
            violCnt_d = violCntInc;
            state_d   = (violCntInc >= MAX_VIOL) ? ST_LOCK : ST_HOLDOFF;
         end
         ST_HOLDOFF: begin
            hcnt_d = hcnt_q + 8'd1;
            if (hcnt_q == HOLD_LAST) begin
               state_d = ST_MONITOR;
            end
         end
         ST_LOCK: begin
            alarm_d = 1'b1;
         end
         default: begin
            state_d = ST_MONITOR;
         end
      endcase
   end

   // State and status registers; reset returns to MONITOR from any state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_MONITOR;
         tcnt_q     <= 8'd0;
         hcnt_q     <= 8'd0;
         violCnt_q  <= 8'd0;
         violCode_q <= 4'd0;
         alarm_q    <= 1'b0;
         supvDec_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         tcnt_q     <= tcnt_d;
         hcnt_q     <= hcnt_d;
         violCnt_q  <= violCnt_d;
         violCode_q <= violCode_d;
         alarm_q    <= alarm_d;
         supvDec_q  <= supvC;
      end
   end

   assign freeze_req = (state_q == ST_FREEZE) || (state_q == ST_EXCEPT) ||
                       (state_q == ST_LOCK);
   assign except_req = (state_q == ST_EXCEPT);
   assign locked     = (state_q == ST_LOCK);
   assign alarm      = alarm_q;
   assign viol_code  = violCode_q;
   assign viol_cnt   = violCnt_q;
   assign supv_dec   = supvDec_q;

`ifdef OR1200_CHECKER_RESP_TSTAMP_EN
   logic [15:0] cycCnt_q;
   logic [15:0] firstTs_q;
   logic        tsHeld_q;
   logic        clrNow;

   assign clrNow = alarm_clr && (state_q == ST_MONITOR);

   // Free-running cycle counter plus capture of the first confirm time
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycCnt_q  <= 16'd0;
         firstTs_q <= 16'd0;
         tsHeld_q  <= 1'b0;
      end else begin
         cycCnt_q <= cycCnt_q + 16'd1;
         if (confirm && (!tsHeld_q || clrNow)) begin
            firstTs_q <= cycCnt_q;
            tsHeld_q  <= 1'b1;
         end else if (clrNow) begin
            firstTs_q <= 16'd0;
            tsHeld_q  <= 1'b0;
         end
      end
   end

   assign first_tstamp = firstTs_q;
`endif

endmodule

// File: tb/tb_or1200_checker_resp.sv
// Self-checking bench for or1200_checker_resp (default parameters, default build).
module tb_or1200_checker_resp;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       chk_en = 1'b1;
   logic       sr_ok = 1'b1;
   logic       pipeline_ok = 1'b1;
   logic       mmus_ok = 1'b1;
   logic [2:0] secure_supv = 3'b000;
   logic       sr_sm = 1'b1;
   logic       cpu_stalled = 1'b0;
   logic       alarm_clr = 1'b0;
   logic       freeze_req;
   logic       except_req;
   logic       alarm;
   logic       locked;
   logic [3:0] viol_code;
   logic [7:0] viol_cnt;
   logic       supv_dec;

   int total = 0;
   int bad = 0;

   typedef enum logic [1:0] {EV_FREEZE = 2'd0, EV_EXCEPT = 2'd1, EV_LOCK = 2'd2} evKind_e;
   typedef struct {
      evKind_e    kind;
      logic [3:0] code;
      logic [7:0] cnt;
   } expEv_t;

   expEv_t expQ[$];

   or1200_checker_resp dut (
      .clk        (clk),
      .rst        (rst),
      .chk_en     (chk_en),
      .sr_ok      (sr_ok),
      .pipeline_ok(pipeline_ok),
      .mmus_ok    (mmus_ok),
      .secure_supv(secure_supv),
      .sr_sm      (sr_sm),
      .cpu_stalled(cpu_stalled),
      .alarm_clr  (alarm_clr),
      .freeze_req (freeze_req),
      .except_req (except_req),
      .alarm      (alarm),
      .locked     (locked),
      .viol_code  (viol_code),
      .viol_cnt   (viol_cnt),
      .supv_dec   (supv_dec)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // okBits = {mmus_ok, pipeline_ok, sr_ok}; advances 'cycles' rising edges
   task automatic applyStimulus(input logic chk, input logic [2:0] okBits,
                                input logic [2:0] supv, input logic sm,
                                input logic stall, input logic clr, input int cycles);
      chk_en = chk;
      {mmus_ok, pipeline_ok, sr_ok} = okBits;
      secure_supv = supv;
      sr_sm = sm;
      cpu_stalled = stall;
      alarm_clr = clr;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic pushEv(input evKind_e k, input logic [3:0] code, input logic [7:0] cnt);
      expEv_t e;
      e.kind = k;
      e.code = code;
      e.cnt  = cnt;
      expQ.push_back(e);
   endtask

   task automatic popAndCheck(input evKind_e k);
      expEv_t e;
      if (expQ.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL unexpectedEvent: got kind %0d, expected none", k);
      end else begin
         e = expQ.pop_front();
         checkOutput("evKind", 16'(k), 16'(e.kind));
         checkOutput("evViolCode", 16'(viol_code), 16'(e.code));
         checkOutput("evViolCnt", 16'(viol_cnt), 16'(e.cnt));
         checkOutput("evAlarm", 16'(alarm), 16'd1);
      end
   endtask

   // Monitor: detects freeze rise, exception pulse and lock entry at negedge
   initial begin
      logic prevF;
      logic prevL;
      prevF = 1'b0;
      prevL = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (freeze_req && !prevF) popAndCheck(EV_FREEZE);
            if (except_req)           popAndCheck(EV_EXCEPT);
            if (locked && !prevL)     popAndCheck(EV_LOCK);
         end
         prevF = freeze_req;
         prevL = locked;
      end
   end

   // Watchdog so the run can never hang
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset values
      #1 rst = 1'b0;
      #2;
      checkOutput("rstFreeze", 16'(freeze_req), 16'd0);
      checkOutput("rstExcept", 16'(except_req), 16'd0);
      checkOutput("rstAlarm", 16'(alarm), 16'd0);
      checkOutput("rstLocked", 16'(locked), 16'd0);
      checkOutput("rstCode", 16'(viol_code), 16'd0);
      checkOutput("rstCnt", 16'(viol_cnt), 16'd0);
      checkOutput("rstSupv", 16'(supv_dec), 16'd1);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;

      // Glitch rejection: single-cycle sr_ok drop
      applyStimulus(1'b1, 3'b110, 3'b000, 1'b1, 1'b0, 1'b0, 1);
      applyStimulus(1'b1, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0, 3);
      checkOutput("glitchFreeze", 16'(freeze_req), 16'd0);
      checkOutput("glitchCode", 16'(viol_code), 16'd0);
      checkOutput("glitchAlarm", 16'(alarm), 16'd0);

      // chk_en low masks a persistent violation
      applyStimulus(1'b0, 3'b110, 3'b000, 1'b1, 1'b0, 1'b0, 3);
      checkOutput("maskFreeze", 16'(freeze_req), 16'd0);
      checkOutput("maskAlarm", 16'(alarm), 16'd0);
      applyStimulus(1'b1, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0, 1);

      // Normal response: pipeline violation, stall acknowledged after 3 cycles
      pushEv(EV_FREEZE, 4'b0010, 8'd0);
      pushEv(EV_EXCEPT, 4'b0010, 8'd0);
      applyStimulus(1'b1, 3'b101, 3'b000, 1'b1, 1'b0, 1'b0, 2);
      checkOutput("normFreeze", 16'(freeze_req), 16'd1);
      checkOutput("normCode", 16'(viol_code), 16'b0010);
      applyStimulus(1'b1, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0, 2);
      applyStimulus(1'b1, 3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 1);
      checkOutput("normExcept", 16'(except_req), 16'd1);
      applyStimulus(1'b1, 3'b111, 3'b000, 1'b1, 1'b0, 1'b1, 1);
      checkOutput("normExceptDone", 16'(except_req), 16'd0);
      checkOutput("normHoldFreeze", 16'(freeze_req), 16'd0);
      checkOutput("normCnt", 16'(viol_cnt), 16'd1);
      // Holdoff: violations and alarm_clr ignored for 8 cycles
      applyStimulus(1'b1, 3'b101, 3'b000, 1'b1, 1'b0, 1'b1, 8);
      checkOutput("holdAlarmKept", 16'(alarm), 16'd1);
      checkOutput("holdCodeKept", 16'(viol_code), 16'b0010);
      checkOutput("holdFreeze", 16'(freeze_req), 16'd0);
      applyStimulus(1'b1, 3'b111, 3'b000, 1'b1, 1'b0, 1'b1, 1);
      checkOutput("monClrAlarm", 16'(alarm), 16'd0);
      checkOutput("monClrCode", 16'(viol_code), 16'd0);

      // Supervisor mismatch, then stall arriving on the timeout cycle
      pushEv(EV_FREEZE, 4'b1000, 8'd1);
      pushEv(EV_EXCEPT, 4'b1000, 8'd1);
      applyStimulus(1'b1, 3'b111, 3'b011, 1'b0, 1'b0, 1'b0, 2);
      checkOutput("supvCode", 16'(viol_code), 16'b1000);
      checkOutput("supvDecOne", 16'(supv_dec), 16'd1);
      applyStimulus(1'b1, 3'b111, 3'b001, 1'b0, 1'b0, 1'b0, 15);
      checkOutput("supvDecZero", 16'(supv_dec), 16'd0);
      checkOutput("preTimeoutLocked", 16'(locked), 16'd0);
      applyStimulus(1'b1, 3'b111, 3'b001, 1'b0, 1'b1, 1'b0, 1);
      checkOutput("stallWinsExcept", 16'(except_req), 16'd1);
      checkOutput("stallWinsLocked", 16'(locked), 16'd0);
      applyStimulus(1'b1, 3'b111, 3'b001, 1'b0, 1'b0, 1'b0, 1);
      checkOutput("supvCnt", 16'(viol_cnt), 16'd2);
      applyStimulus(1'b1, 3'b111, 3'b001, 1'b0, 1'b0, 1'b0, 8);
      checkOutput("supvBackFreeze", 16'(freeze_req), 16'd0);

      // Third violation with alarm_clr on the confirm cycle -> escalates to LOCK
      pushEv(EV_FREEZE, 4'b0100, 8'd2);
      pushEv(EV_EXCEPT, 4'b0100, 8'd2);
      pushEv(EV_LOCK,   4'b0100, 8'd3);
      applyStimulus(1'b1, 3'b011, 3'b001, 1'b0, 1'b0, 1'b0, 1);
      applyStimulus(1'b1, 3'b011, 3'b001, 1'b0, 1'b0, 1'b1, 1);
      checkOutput("setWinsCode", 16'(viol_code), 16'b0100);
      checkOutput("setWinsAlarm", 16'(alarm), 16'd1);
      applyStimulus(1'b1, 3'b111, 3'b001, 1'b0, 1'b1, 1'b0, 1);
      applyStimulus(1'b0, 3'b111, 3'b001, 1'b0, 1'b0, 1'b1, 1);
      checkOutput("escLocked", 16'(locked), 16'd1);
      checkOutput("escCnt", 16'(viol_cnt), 16'd3);
      applyStimulus(1'b0, 3'b111, 3'b001, 1'b0, 1'b0, 1'b1, 3);
      checkOutput("lockAlarm", 16'(alarm), 16'd1);
      checkOutput("lockFreeze", 16'(freeze_req), 16'd1);
      checkOutput("lockCode", 16'(viol_code), 16'b0100);
      checkOutput("lockStays", 16'(locked), 16'd1);

      // Asynchronous reset while locked, sampled before any clock edge
      #2 rst = 1'b0;
      #1;
      checkOutput("arstLocked", 16'(locked), 16'd0);
      checkOutput("arstFreeze", 16'(freeze_req), 16'd0);
      checkOutput("arstCnt", 16'(viol_cnt), 16'd0);
      checkOutput("arstSupv", 16'(supv_dec), 16'd1);
      checkOutput("arstAlarm", 16'(alarm), 16'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;

      // Stall timeout: no acknowledge for 16 FREEZE cycles -> LOCK
      pushEv(EV_FREEZE, 4'b0001, 8'd0);
      pushEv(EV_LOCK,   4'b0001, 8'd0);
      applyStimulus(1'b1, 3'b110, 3'b000, 1'b1, 1'b0, 1'b0, 2);
      applyStimulus(1'b1, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0, 15);
      checkOutput("toNotYet", 16'(locked), 16'd0);
      checkOutput("toFreeze", 16'(freeze_req), 16'd1);
      applyStimulus(1'b1, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0, 1);
      checkOutput("toLocked", 16'(locked), 16'd1);
      applyStimulus(1'b1, 3'b111, 3'b000, 1'b1, 1'b0, 1'b1, 2);
      checkOutput("toClrAlarm", 16'(alarm), 16'd1);
      checkOutput("toClrCode", 16'(viol_code), 16'b0001);
      checkOutput("toCnt", 16'(viol_cnt), 16'd0);

      // Finish: return to reset and confirm every expected event was seen
      rst = 1'b0;
      applyStimulus(1'b1, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0, 2);
      checkOutput("pendingEvents", 16'(expQ.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
